// File: rtl/icache_pkg.sv
// Shared definitions for the N-way instruction cache: line geometry, FSM
// states and address-field width helpers.
package icache_pkg;

  localparam int OFFSET_BITS = 5;
  localparam int LINE_BITS   = 256;

  typedef enum logic {
    CHECK = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  function automatic int idx_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_bits(input int num_sets);
    return 32 - OFFSET_BITS - idx_bits(num_sets);
  endfunction

endpackage

// File: rtl/icache_nway_plru.sv
// Combinational tree pseudo-LRU: walks the heap-ordered tree bits to pick a
// victim and computes the tree that marks an accessed way most-recently-used.
module plru_tree #(
  parameter int NUM_WAYS = 2
) (
  input  logic [NUM_WAYS-2:0]         tree_cur,
  input  logic [$clog2(NUM_WAYS)-1:0] access_way,
  input  logic                        access_valid,
  output logic [NUM_WAYS-2:0]         tree_next,
  output logic [$clog2(NUM_WAYS)-1:0] victim
);

  localparam int WAY_W = $clog2(NUM_WAYS);

  logic [WAY_W-1:0] vic_node;
  logic [WAY_W-1:0] upd_node;

  // A 0 bit sends the victim to the lower half; each access flips its path away.
  always_comb begin
    tree_next = tree_cur;
    victim    = '0;
    vic_node  = '0;
    upd_node  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      victim[WAY_W-1-l] = tree_cur[vic_node];
      vic_node = WAY_W'(2 * int'(vic_node) + 1 + int'(tree_cur[vic_node]));
    end
    if (access_valid) begin
      for (int l = 0; l < WAY_W; l++) begin
        tree_next[upd_node] = ~access_way[WAY_W-1-l];
        upd_node = WAY_W'(2 * int'(upd_node) + 1 + int'(access_way[WAY_W-1-l]));
      end
    end
  end

endmodule

// File: rtl/icache_nway.sv
// Read-only N-way set-associative instruction cache with tree PLRU and flush.
// Optional hit/miss counters are enabled with the ICACHE_PERF_CNT_EN macro.
module icache_nway #(
  parameter int NUM_WAYS  = 2,
  parameter int NUM_SETS  = 8,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_a,
  input  logic [31:0]          address_a,
  output logic [31:0]          rdata_a,
  output logic                 resp_a,
  input  logic                 flush_a,
  output logic                 pmem_read_a,
  input  logic                 pmem_resp_a,
  input  logic [LINE_BITS-1:0] pmem_rdata_a,
  output logic [31:0]          pmem_addr_a
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]          hit_count_a,
  output logic [31:0]          miss_count_a
`endif
);

  import icache_pkg::*;

  localparam int IDX_W = idx_bits(NUM_SETS);
  localparam int TAG_W = tag_bits(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);

  icache_state_t state, state_next;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid;
  logic [NUM_SETS-1:0][NUM_WAYS-2:0] plru;
  logic [TAG_W-1:0]     tags  [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0] lines [NUM_SETS][NUM_WAYS];
  logic                 flush_pending;

  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [NUM_WAYS-1:0]  hit_vec;
  logic [WAY_W-1:0]     hit_way, inv_way, plru_victim, fill_way, access_way;
  logic                 any_invalid;
  logic                 fill;
  logic [NUM_WAYS-2:0]  plru_next;
  logic [LINE_BITS-1:0] hit_line;
  logic                 unused_addr_bits;

  assign idx              = address_a[OFFSET_BITS +: IDX_W];
  assign tag              = address_a[31 -: TAG_W];
  assign pmem_addr_a      = {address_a[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign unused_addr_bits = ^address_a[1:0];

  // Descending scan leaves the lowest-numbered invalid way as the fill candidate.
  always_comb begin
    hit_vec     = '0;
    hit_way     = '0;
    inv_way     = '0;
    any_invalid = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid[idx][w] && (tags[idx][w] == tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (!valid[idx][w]) begin
        inv_way     = WAY_W'(w);
        any_invalid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    resp_a      = 1'b0;
    pmem_read_a = 1'b0;
    fill        = 1'b0;
    unique case (state)
      CHECK: begin
        if (read_a) begin
          if (|hit_vec) resp_a = 1'b1;
          else          state_next = FETCH;
        end
      end
      FETCH: begin
        pmem_read_a = 1'b1;
        if (pmem_resp_a) begin
          fill       = 1'b1;
          state_next = CHECK;
        end
      end
      default: state_next = CHECK;
    endcase
  end

  assign hit_line   = lines[idx][hit_way];
  assign rdata_a    = resp_a ? hit_line[{address_a[4:2], 5'b0} +: 32] : 32'h0;
  assign fill_way   = any_invalid ? inv_way : plru_victim;
  assign access_way = fill ? fill_way : hit_way;

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .tree_cur     (plru[idx]),
    .access_way   (access_way),
    .access_valid (resp_a | fill),
    .tree_next    (plru_next),
    .victim       (plru_victim)
  );

  // A flush seen during a fetch is held until the fill lands, then wipes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= CHECK;
      valid         <= '0;
      plru          <= '0;
      flush_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (state == CHECK) begin
        flush_pending <= 1'b0;
        if (flush_a) begin
          valid <= '0;
          plru  <= '0;
        end else if (resp_a) begin
          plru[idx] <= plru_next;
        end
      end else if (fill) begin
        flush_pending <= 1'b0;
        if (flush_pending || flush_a) begin
          valid <= '0;
          plru  <= '0;
        end else begin
          valid[idx][fill_way] <= 1'b1;
          plru[idx]            <= plru_next;
        end
      end else if (flush_a) begin
        flush_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      lines[idx][fill_way] <= pmem_rdata_a;
      tags[idx][fill_way]  <= tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_a  <= '0;
      miss_count_a <= '0;
    end else begin
      if (resp_a) hit_count_a <= hit_count_a + 32'd1;
      if (state == CHECK && state_next == FETCH) miss_count_a <= miss_count_a + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_nway.sv
// Randomised bench for icache_nway (4 ways, 8 sets) against a behavioural
// cache model; counter checks are compiled in with ICACHE_PERF_CNT_EN.
module tb_icache_nway;

  localparam int NUM_WAYS = 4;
  localparam int NUM_SETS = 8;
  localparam int IDX      = $clog2(NUM_SETS);

  logic         clk = 1'b0;
  logic         rst;
  logic         read_a;
  logic [31:0]  address_a;
  logic [31:0]  rdata_a;
  logic         resp_a;
  logic         flush_a;
  logic         pmem_read_a;
  logic         pmem_resp_a;
  logic [255:0] pmem_rdata_a;
  logic [31:0]  pmem_addr_a;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_count_a;
  logic [31:0]  miss_count_a;
`endif

  int total = 0;
  int bad   = 0;

  bit           m_valid [NUM_SETS][NUM_WAYS];
  logic [31:0]  m_tag   [NUM_SETS][NUM_WAYS];
  logic [255:0] m_line  [NUM_SETS][NUM_WAYS];
  bit           m_plru  [NUM_SETS][NUM_WAYS];
  int           m_hits, m_misses;

  bit           force_en;
  logic [31:0]  force_word2;

  icache_nway #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS), .LINE_BITS(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .read_a       (read_a),
    .address_a    (address_a),
    .rdata_a      (rdata_a),
    .resp_a       (resp_a),
    .flush_a      (flush_a),
    .pmem_read_a  (pmem_read_a),
    .pmem_resp_a  (pmem_resp_a),
    .pmem_rdata_a (pmem_rdata_a),
    .pmem_addr_a  (pmem_addr_a)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count_a  (hit_count_a),
    .miss_count_a (miss_count_a)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 5) & (NUM_SETS - 1));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (5 + IDX);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < NUM_WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_plru[s][w]  = 1'b0;
      end
    m_hits   = 0;
    m_misses = 0;
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < NUM_WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_plru[s][w]  = 1'b0;
      end
  endfunction

  // Tree walked as nested halves of the way range; node numbering is heap order.
  function automatic int model_victim(input int s);
    int lo = 0, size = NUM_WAYS, node = 0;
    while (size > 1) begin
      size = size / 2;
      if (m_plru[s][node]) begin
        lo   = lo + size;
        node = 2 * node + 2;
      end else begin
        node = 2 * node + 1;
      end
    end
    return lo;
  endfunction

  function automatic void model_touch(input int s, input int w);
    int lo = 0, size = NUM_WAYS, node = 0;
    while (size > 1) begin
      size = size / 2;
      if (w >= lo + size) begin
        m_plru[s][node] = 1'b0;
        lo   = lo + size;
        node = 2 * node + 2;
      end else begin
        m_plru[s][node] = 1'b1;
        node = 2 * node + 1;
      end
    end
  endfunction

  function automatic int model_lookup(input logic [31:0] a);
    for (int w = 0; w < NUM_WAYS; w++)
      if (m_valid[set_of(a)][w] && m_tag[set_of(a)][w] == tag_of(a)) return w;
    return -1;
  endfunction

  function automatic void model_fill(input logic [31:0] a, input logic [255:0] line);
    int s = set_of(a);
    int v = -1;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!m_valid[s][w]) v = w;
    if (v < 0) v = model_victim(s);
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = tag_of(a);
    m_line[s][v]  = line;
    model_touch(s, v);
  endfunction

  task automatic doFlush();
    @(negedge clk);
    read_a  = 1'b0;
    flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
    model_flush();
  endtask

  // One fetch request, held until it hits; services every line fetch it causes.
  task automatic applyStimulus(input logic [31:0] addr, input bit flush_now, input bit flush_in_fetch,
                               output bit was_hit, output logic [31:0] rdata_seen, output int n_fills);
    int           way, lat, s, word;
    bit           done, fif;
    logic [255:0] line;
    s          = set_of(addr);
    word       = int'(addr[4:2]);
    fif        = flush_in_fetch;
    was_hit    = 1'b0;
    rdata_seen = '0;
    n_fills    = 0;
    done       = 1'b0;
    @(negedge clk);
    read_a    = 1'b1;
    address_a = addr;
    flush_a   = flush_now;
    for (int attempt = 0; attempt < 4 && !done; attempt++) begin
      #1;
      way = model_lookup(addr);
      checkOutput("hit_onehot", 32'($onehot0(dut.hit_vec)), 32'd1);
      checkOutput("resp_a", {31'b0, resp_a}, {31'b0, way >= 0});
      checkOutput("pmem_read_in_check", {31'b0, pmem_read_a}, 32'd0);
      if (way >= 0) begin
        checkOutput("rdata_a", rdata_a, m_line[s][way][32*word +: 32]);
        rdata_seen = rdata_a;
        was_hit    = (attempt == 0);
        m_hits++;
        model_touch(s, way);
        if (flush_a) model_flush();
        done = 1'b1;
        @(negedge clk);
        read_a  = 1'b0;
        flush_a = 1'b0;
      end else begin
        if (flush_a) model_flush();
        m_misses++;
        @(negedge clk);
        flush_a = 1'b0;
        #1;
        checkOutput("pmem_read_a", {31'b0, pmem_read_a}, 32'd1);
        checkOutput("pmem_addr_a", pmem_addr_a, {addr[31:5], 5'b0});
        lat = $urandom_range(0, 3);
        for (int c = 0; c < lat; c++) begin
          if (fif && c == 0) flush_a = 1'b1;
          @(negedge clk);
          flush_a = 1'b0;
          #1;
          checkOutput("pmem_read_hold", {31'b0, pmem_read_a}, 32'd1);
        end
        if (fif && lat == 0) flush_a = 1'b1;
        for (int k = 0; k < 8; k++) line[32*k +: 32] = $urandom;
        if (force_en) line[95:64] = force_word2;
        pmem_resp_a  = 1'b1;
        pmem_rdata_a = line;
        @(negedge clk);
        pmem_resp_a = 1'b0;
        flush_a     = 1'b0;
        for (int k = 0; k < 8; k++) pmem_rdata_a[32*k +: 32] = $urandom;
        model_fill(addr, line);
        if (fif) model_flush();
        fif = 1'b0;
        n_fills++;
      end
    end
    checkOutput("read_completed", {31'b0, done}, 32'd1);
    read_a = 1'b0;
  endtask

  initial begin
    bit          h;
    logic [31:0] rd;
    int          nf;
    logic [31:0] a;
    rst          = 1'b1;
    read_a       = 1'b0;
    address_a    = '0;
    flush_a      = 1'b0;
    pmem_resp_a  = 1'b0;
    pmem_rdata_a = '0;
    force_en     = 1'b0;
    force_word2  = '0;
    model_reset();
    #2;
    checkOutput("reset_resp_a", {31'b0, resp_a}, 32'd0);
    checkOutput("reset_pmem_read_a", {31'b0, pmem_read_a}, 32'd0);
    checkOutput("reset_rdata_a", rdata_a, 32'd0);
`ifdef ICACHE_PERF_CNT_EN
    checkOutput("reset_hit_count", hit_count_a, 32'd0);
    checkOutput("reset_miss_count", miss_count_a, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Cold miss followed by a zero-latency hit on another word of the line.
    force_en    = 1'b1;
    force_word2 = 32'hDEAD_BEEF;
    applyStimulus(32'h0000_0040, 1'b0, 1'b0, h, rd, nf);
    checkOutput("cold_miss_fills", nf, 32'd1);
    force_en = 1'b0;
    applyStimulus(32'h0000_0048, 1'b0, 1'b0, h, rd, nf);
    checkOutput("cold_rehit", {31'b0, h}, 32'd1);
    checkOutput("cold_word2", rd, 32'hDEAD_BEEF);

    // Flush in CHECK alongside a hit: the hit is served, the next read misses.
    applyStimulus(32'h0000_0040, 1'b1, 1'b0, h, rd, nf);
    checkOutput("flush_check_hit", {31'b0, h}, 32'd1);
    applyStimulus(32'h0000_0040, 1'b0, 1'b0, h, rd, nf);
    checkOutput("after_flush_miss", {31'b0, h}, 32'd0);

    // Fill set 0, touch 0x000, then 0x400 evicts the PLRU way (holding 0x200).
    doFlush();
    for (int t = 0; t < 4; t++) applyStimulus(32'(t) << 8, 1'b0, 1'b0, h, rd, nf);
    applyStimulus(32'h0000_0000, 1'b0, 1'b0, h, rd, nf);
    applyStimulus(32'h0000_0400, 1'b0, 1'b0, h, rd, nf);
    checkOutput("evict_new_miss", {31'b0, h}, 32'd0);
    applyStimulus(32'h0000_0000, 1'b0, 1'b0, h, rd, nf);
    checkOutput("evict_keep_000", {31'b0, h}, 32'd1);
    applyStimulus(32'h0000_0100, 1'b0, 1'b0, h, rd, nf);
    checkOutput("evict_keep_100", {31'b0, h}, 32'd1);
    applyStimulus(32'h0000_0200, 1'b0, 1'b0, h, rd, nf);
    checkOutput("evict_gone_200", {31'b0, h}, 32'd0);

    // Invalid ways are used before the PLRU choice.
    doFlush();
    applyStimulus(32'h0000_0000, 1'b0, 1'b0, h, rd, nf);
    applyStimulus(32'h0000_0100, 1'b0, 1'b0, h, rd, nf);
    applyStimulus(32'h0000_0000, 1'b0, 1'b0, h, rd, nf);
    checkOutput("invalid_first_keep", {31'b0, h}, 32'd1);

    // Flush during a fetch: the fill is discarded and the read misses again.
    applyStimulus(32'h0000_0080, 1'b0, 1'b1, h, rd, nf);
    checkOutput("flush_fetch_fills", nf, 32'd2);

    for (int i = 0; i < 200; i++) begin
      a = (32'($urandom_range(0, 5)) << (5 + IDX)) | (32'($urandom_range(0, 1)) << 5)
        | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) doFlush();
      applyStimulus(a, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, h, rd, nf);
    end

`ifdef ICACHE_PERF_CNT_EN
    checkOutput("hit_count", hit_count_a, 32'(m_hits));
    checkOutput("miss_count", miss_count_a, 32'(m_misses));
`endif

    // Reset while fetching drops the request immediately.
    doFlush();
    @(negedge clk);
    read_a    = 1'b1;
    address_a = 32'h0000_0300;
    #1;
    checkOutput("rst_pre_resp", {31'b0, resp_a}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rst_pre_pmem", {31'b0, pmem_read_a}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_pmem", {31'b0, pmem_read_a}, 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    read_a = 1'b0;
    model_reset();
`ifdef ICACHE_PERF_CNT_EN
    #1;
    checkOutput("rst_hit_count", hit_count_a, 32'd0);
    checkOutput("rst_miss_count", miss_count_a, 32'd0);
`endif
    applyStimulus(32'h0000_0000, 1'b0, 1'b0, h, rd, nf);
    checkOutput("post_rst_miss0", {31'b0, h}, 32'd0);
    applyStimulus(32'h0000_0100, 1'b0, 1'b0, h, rd, nf);
    checkOutput("post_rst_miss1", {31'b0, h}, 32'd0);
    applyStimulus(32'h0000_0040, 1'b0, 1'b0, h, rd, nf);
    checkOutput("post_rst_miss2", {31'b0, h}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
